uart_tx_frame_arbiter: RTL

- Shares the single uart_tx instance between up to N_SRC byte-stream message sources, e.g. custom_msg_generator, an order-ack reporter and a status/heartbeat reporter.
- Arbitrates round-robin at frame granularity: once a source is granted, all its bytes up to and including the byte flagged last go out before re-arbitration.
- Sequences each byte into the uart_tx tx_start/tx_data/tx_busy handshake.
- Sits between the message generators and uart_tx in HFT_top.

---
 rtl/uart_tx_frame_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_arbiter
// Description : Round-robin, frame-granular arbiter that shares one uart_tx
//               between N_SRC byte-stream sources. A granted source keeps the
//               transmitter until its byte flagged "last" has drained.
//               Optional mid-frame stall timeout: define UART_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame_arbiter #(
    parameter int N_SRC       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [8*N_SRC-1:0]         src_data,
    input  logic [N_SRC-1:0]           src_last,
    output logic [N_SRC-1:0]           src_ready,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic [$clog2(N_SRC)-1:0]   grant_id,
    output logic                       arb_busy,
    output logic                       frame_done,
    output logic                       frame_abort
);

    localparam int GW = $clog2(N_SRC);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GUARD = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_last_grant;
    logic            r_last_flag;

    logic [GW-1:0]   w_winner;
    logic            w_any;
    logic            w_sel_valid;
    logic            w_sel_last;
    logic [7:0]      w_sel_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]   r_to_cnt;
`endif

    // Round-robin search: first valid source starting after the last grant.
    always_comb begin : rr_search
        logic [GW:0] idx;
        w_winner = '0;
        w_any    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = {1'b0, r_last_grant} + (GW+1)'(k);
            if (idx >= (GW+1)'(N_SRC)) begin
                idx = idx - (GW+1)'(N_SRC);
            end
            if (!w_any && src_valid[idx[GW-1:0]]) begin
                w_winner = idx[GW-1:0];
                w_any    = 1'b1;
            end
        end
    end

    // Select the granted source's byte, last flag and valid.
    always_comb begin : grant_mux
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_id == GW'(i)) begin
                w_sel_valid = src_valid[i];
                w_sel_last  = src_last[i];
                w_sel_data  = src_data[8*i +: 8];
            end
        end
    end

    // Accept strobe is combinational so the source sees it in the same
    // cycle the byte is latched; it can only ever be high in LOAD.
    always_comb begin : ready_decode
        src_ready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_ready[i] = (r_state == ST_LOAD) && w_sel_valid && (grant_id == GW'(i));
        end
    end

    assign arb_busy = (r_state != ST_IDLE);

`ifndef UART_ARB_TIMEOUT_EN
    assign frame_abort = 1'b0;
`endif

    // Main sequencer: arbitration, byte load, tx_start issue and drain wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GW'(N_SRC - 1);
            r_last_flag  <= 1'b0;
            grant_id     <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            frame_done   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_to_cnt     <= '0;
            frame_abort  <= 1'b0;
`endif
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            frame_abort <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_any && !tx_busy) begin
                        grant_id     <= w_winner;
                        r_last_grant <= w_winner;
                        r_state      <= ST_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                        r_to_cnt     <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (w_sel_valid) begin
                        tx_data     <= w_sel_data;
                        r_last_flag <= w_sel_last;
                        tx_start    <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        // Stalled source gives up the transmitter; its grant
                        // stays recorded so it drops to lowest priority.
                        frame_abort <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                ST_ISSUE: begin
                    r_state <= ST_GUARD;
                end
                ST_GUARD: begin
                    // uart_tx needs a cycle before tx_busy reflects the start.
                    r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!tx_busy) begin
                        if (r_last_flag) begin
                            frame_done <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_state <= ST_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                            r_to_cnt <= '0;
`endif
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
